// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and AXI encodings for the instruction-fetch master
package ifetch_pkg;
  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_BITS = 4;
  localparam int TAG_W = 32 - OFFSET_BITS;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
endpackage

// File: rtl/fetch_line_buf.sv
// fetch_line_buf: single 4-word line with tag, valid, one write port and a read mux
module fetch_line_buf
  import ifetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inv,
  input  logic             set_valid,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             we,
  input  logic [1:0]       widx,
  input  logic [31:0]      wdata,
  input  logic [1:0]       ridx,
  output logic [TAG_W-1:0] tag,
  output logic             valid,
  output logic [31:0]      rdata
);
  logic [31:0] mem [LINE_WORDS];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag <= '0;
    end else begin
      valid <= inv ? 1'b0 : set_valid ? 1'b1 : valid;
      if (tag_we) tag <= tag_in;
    end
  end
  always_ff @(posedge clk) if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/ifetch_axi_master.sv
// ifetch_axi_master: AXI4 read master serving CPU fetches from a one-line buffer
module ifetch_axi_master
  import ifetch_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        flush,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);
  state_t state, state_n;
  logic [31:2] addr;
  logic [1:0] cnt;
  logic err, flush_seen, acc, hit, ar_hs, r_hs, r_done, beat_err, line_valid, addr_lsb_unused;
  logic [TAG_W-1:0] tag;
  logic [31:0] word;
  assign addr_lsb_unused = ^if_req_addr[1:0];
  assign acc = if_req_valid & if_req_ready;
  assign hit = line_valid & ~flush & (tag == if_req_addr[31:OFFSET_BITS]);
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs = RVALID & RREADY;
  assign r_done = r_hs & (RLAST | cnt == 2'd3);
  // RLAST must coincide exactly with the fourth beat
  assign beat_err = (RRESP != RESP_OKAY) | (RID != MASTER_ID) | (RLAST != (cnt == 2'd3));
  assign ARID = MASTER_ID;
  assign ARLEN = 4'(LINE_WORDS - 1);
  assign ARSIZE = SIZE_4B;
  assign ARBURST = BURST_INCR;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (acc ? (hit ? RSP : AR) : IDLE) :
              state == AR   ? (ar_hs ? R : AR) :
              state == R    ? (r_done ? RSP : R) : IDLE;
  end
  always_comb begin
    if_req_ready = (state == IDLE) & ~rst;
    ARVALID = state == AR;
    ARADDR = ARVALID ? {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
    RREADY = state == R;
    if_rsp_valid = (state == RSP) & ~flush_seen & ~flush;
    if_rsp_data = if_rsp_valid ? word : '0;
    if_rsp_err = if_rsp_valid & err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt <= '0;
      err <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      if (acc) begin
        addr <= if_req_addr[31:2];
        cnt <= '0;
        err <= 1'b0;
        flush_seen <= 1'b0;
      end
      if (r_hs) begin
        cnt <= cnt + 2'd1;
        err <= err | beat_err;
      end
      if ((state == AR || state == R) && flush) flush_seen <= 1'b1;
    end
  end
  fetch_line_buf u_line (
    .clk       (clk),
    .rst       (rst),
    .inv       ((flush & (state == IDLE || state == RSP)) | (acc & ~hit)),
    .set_valid (r_done & ~(err | beat_err) & ~(flush_seen | flush)),
    .tag_we    (acc & ~hit),
    .tag_in    (if_req_addr[31:OFFSET_BITS]),
    .we        (r_hs),
    .widx      (cnt),
    .wdata     (RDATA),
    .ridx      (addr[3:2]),
    .tag       (tag),
    .valid     (line_valid),
    .rdata     (word)
  );
endmodule

// File: tb/tb_ifetch_axi_master.sv
// tb_ifetch_axi_master: directed checks of hit/miss, bus stalls, errors, flush and reset
module tb_ifetch_axi_master;
  logic clk = 0, rst = 1, if_req_valid = 0, flush = 0, ARREADY = 0, RLAST = 0, RVALID = 0;
  logic [31:0] if_req_addr = 0, RDATA = 0, ARADDR, if_rsp_data;
  logic [3:0] RID = 0, ARID, ARLEN;
  logic [1:0] RRESP = 0, ARBURST;
  logic [2:0] ARSIZE;
  logic if_req_ready, if_rsp_valid, if_rsp_err, ARVALID, RREADY;
  int n_cmp = 0, n_fail = 0, cyc = 0, ar_cnt = 0, acc_cyc = 0;
  ifetch_axi_master #(.MASTER_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err), .flush(flush), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ARVALID && ARREADY) ar_cnt <= ar_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [31:0] a);
    @(negedge clk);
    if_req_valid = 1;
    if_req_addr = a;
    #1 chk("req_ready", if_req_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    if_req_valid = 0;
  endtask
  task automatic ar(input int wait_n, input logic [31:0] a);
    for (int i = 0; i < wait_n; i++) begin
      #1 chk("arvalid_hold", ARVALID, 1);
      chk("araddr_hold", ARADDR, a);
      chk("rready_in_ar", RREADY, 0);
      @(negedge clk);
    end
    ARREADY = 1;
    #1 chk("arvalid", ARVALID, 1);
    chk("araddr", ARADDR, a);
    chk("arlen", ARLEN, 3);
    @(negedge clk);
    ARREADY = 0;
  endtask
  task automatic beat(input int gap, input logic [31:0] d, input logic [1:0] resp, input logic last);
    for (int i = 0; i < gap; i++) begin
      #1 chk("rready_gap", RREADY, 1);
      @(negedge clk);
    end
    RVALID = 1;
    RDATA = d;
    RRESP = resp;
    RLAST = last;
    #1 chk("rready", RREADY, 1);
    @(negedge clk);
    RVALID = 0;
    RDATA = 0;
    RRESP = 0;
    RLAST = 0;
  endtask
  task automatic burst(input logic [31:0] base);
    for (int i = 0; i < 4; i++) beat(0, base + 32'(i), 2'b00, i == 3);
  endtask
  task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
    #1 chk({tag, "_valid"}, if_rsp_valid, v);
    chk({tag, "_data"}, if_rsp_data, d);
    chk({tag, "_err"}, if_rsp_err, e);
    chk("rready_rsp", RREADY, 0);
    @(negedge clk);
    #1 chk({tag, "_pulse"}, if_rsp_valid, 0);
    chk("ready_idle", if_req_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1 chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rsp_valid", if_rsp_valid, 0);
    chk("rst_req_ready", if_req_ready, 0);
    chk("rst_arsize", ARSIZE, 3'b010);
    chk("rst_arburst", ARBURST, 2'b01);
    chk("rst_arlen", ARLEN, 4'd3);
    chk("rst_arid", ARID, 4'd0);
    rst = 0;
    req(32'h104);
    ar(0, 32'h100);
    burst(32'hA0);
    #1 chk("cold_lat", cyc - acc_cyc, 6);
    chk("cold_ar_cnt", ar_cnt, 1);
    rsp("cold", 1, 32'hA1, 0);
    req(32'h10C);
    #1 chk("hit_lat", cyc - acc_cyc, 1);
    chk("hit_no_arvalid", ARVALID, 0);
    rsp("hit", 1, 32'hA3, 0);
    chk("hit_ar_cnt", ar_cnt, 1);
    req(32'h208);
    ar(5, 32'h200);
    beat(2, 32'hB0, 2'b00, 0);
    beat(0, 32'hB1, 2'b00, 0);
    beat(1, 32'hB2, 2'b00, 0);
    beat(3, 32'hB3, 2'b00, 1);
    rsp("stall", 1, 32'hB2, 0);
    req(32'h104);
    ar(0, 32'h100);
    beat(0, 32'hC0, 2'b00, 0);
    beat(0, 32'hC1, 2'b00, 0);
    beat(0, 32'hC2, 2'b10, 0);
    beat(0, 32'hC3, 2'b00, 1);
    rsp("slverr", 1, 32'hC1, 1);
    req(32'h104);
    #1 chk("retry_arvalid", ARVALID, 1);
    ar(0, 32'h100);
    burst(32'hD0);
    rsp("retry", 1, 32'hD1, 0);
    req(32'h300);
    ar(0, 32'h300);
    beat(0, 32'hE0, 2'b00, 0);
    flush = 1;
    beat(0, 32'hE1, 2'b00, 0);
    flush = 0;
    beat(0, 32'hE2, 2'b00, 0);
    beat(0, 32'hE3, 2'b00, 1);
    rsp("flush", 0, 32'h0, 0);
    req(32'h104);
    #1 chk("post_flush_arvalid", ARVALID, 1);
    ar(0, 32'h100);
    burst(32'h10);
    rsp("post_flush", 1, 32'h11, 0);
    req(32'h400);
    ar(0, 32'h400);
    beat(0, 32'hF0, 2'b00, 1);
    rsp("short", 1, 32'hF0, 1);
    req(32'h500);
    ar(0, 32'h500);
    beat(0, 32'h50, 2'b00, 0);
    #1 chk("mid_burst_rready", RREADY, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("rst_r_arvalid", ARVALID, 0);
    chk("rst_r_rready", RREADY, 0);
    chk("rst_r_req_ready", if_req_ready, 1);
    chk("rst_r_rsp_valid", if_rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
